// File: rtl/fifo_pkg.sv
// Shared definitions for the team's FIFO family (synchronous and asynchronous).
// Holds read-mode encodings, depth/count-width helpers and the flag bundle.
package fifo_pkg;

    // Read-mode encodings for the fwft parameter
    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Status flags derived purely from an occupancy value
    typedef struct packed {
        logic empty;
        logic full;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    // Number of entries for a given address width
    function automatic int fifo_depth(input int addr_size);
        return 1 << addr_size;
    endfunction

    // Occupancy counter width: must hold 0..depth inclusive
    function automatic int fifo_count_width(input int addr_size);
        return addr_size + 1;
    endfunction

    // Flag set for a given occupancy; thresholds are inclusive on both sides
    function automatic fifo_flags_t fifo_flags_from_count(
        input int count,
        input int depth,
        input int afull_level,
        input int aempty_level
    );
        fifo_flags_t f;
        f.empty        = (count == 0);
        f.full         = (count == depth);
        f.almost_full  = (count >= afull_level);
        f.almost_empty = (count <= aempty_level);
        return f;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array for the FIFO family: one synchronous write port and one
// asynchronous read port. Contents are never reset.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int data_size = 8,
    parameter int addr_size = 3
) (
    input  logic                 clk,
    input  logic                 write_en,
    input  logic [addr_size-1:0] write_addr,
    input  logic [data_size-1:0] write_data,
    input  logic [addr_size-1:0] read_addr,
    output logic [data_size-1:0] read_data
);

    localparam int depth = fifo_depth(addr_size);

    logic [data_size-1:0] mem [depth];

    // Synchronous write of one entry per cycle
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[write_addr] <= write_data;
        end
    end

    assign read_data = mem[read_addr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and a registered or fall-through read port.
// Flags are registered from the next count so they always agree with fifo_count.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int data_size    = 8,
    parameter int addr_size    = 3,
    parameter int afull_level  = 6,
    parameter int aempty_level = 2,
    parameter int fwft         = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 write_en,
    input  logic [data_size-1:0] write_data,
    input  logic                 read_en,
    output logic [data_size-1:0] read_data,
    output logic                 fifo_empty,
    output logic                 fifo_full,
    output logic                 fifo_almost_full,
    output logic                 fifo_almost_empty,
    output logic [addr_size:0]   fifo_count,
    output logic                 overflow,
    output logic                 underflow,
    input  logic                 err_clr
);

    localparam int depth   = fifo_depth(addr_size);
    localparam int count_w = fifo_count_width(addr_size);

    logic [addr_size-1:0] wr_ptr;
    logic [addr_size-1:0] rd_ptr;
    logic [count_w-1:0]   count_next;
    logic                 wr_accept;
    logic                 rd_accept;
    logic [data_size-1:0] ram_read_data;
    fifo_flags_t          flags_next;

    // Acceptance looks only at the registered flags, so full/empty arbitration
    // never depends on same-cycle requests.
    assign wr_accept = write_en & ~fifo_full;
    assign rd_accept = read_en & ~fifo_empty;

    fifo_ram #(
        .data_size (data_size),
        .addr_size (addr_size)
    ) u_ram (
        .clk        (clk),
        .write_en   (wr_accept),
        .write_addr (wr_ptr),
        .write_data (write_data),
        .read_addr  (rd_ptr),
        .read_data  (ram_read_data)
    );

    // Next occupancy: a simultaneous read and write leaves the count unchanged
    always_comb begin
        count_next = fifo_count;
        unique case ({wr_accept, rd_accept})
            2'b10:   count_next = fifo_count + 1'b1;
            2'b01:   count_next = fifo_count - 1'b1;
            default: count_next = fifo_count;
        endcase
    end

    assign flags_next = fifo_flags_from_count(int'(count_next), depth,
                                              afull_level, aempty_level);

    // Pointers wrap naturally at depth because they are exactly addr_size wide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Count and flags register together from the same next-count value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_count        <= '0;
            fifo_empty        <= 1'b1;
            fifo_full         <= 1'b0;
            fifo_almost_full  <= 1'b0;
            fifo_almost_empty <= 1'b1;
        end else begin
            fifo_count        <= count_next;
            fifo_empty        <= flags_next.empty;
            fifo_full         <= flags_next.full;
            fifo_almost_full  <= flags_next.almost_full;
            fifo_almost_empty <= flags_next.almost_empty;
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (write_en & fifo_full)  | (overflow  & ~err_clr);
            underflow <= (read_en  & fifo_empty) | (underflow & ~err_clr);
        end
    end

    if (fwft == FIFO_MODE_FWFT) begin : g_fwft
        // Head of queue is presented directly; meaningless while empty
        assign read_data = ram_read_data;
    end else begin : g_std
        logic [data_size-1:0] read_data_q;

        // Registered read port: captures the head on an accepted read, holds otherwise
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                read_data_q <= '0;
            end else if (rd_accept) begin
                read_data_q <= ram_read_data;
            end
        end

        assign read_data = read_data_q;
    end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: a standard-mode and an FWFT-mode instance share
// one stimulus stream and are compared against a queue-based reference.
module tb_sync_fifo_flags;

    localparam int DW     = 8;
    localparam int AW     = 3;
    localparam int DEPTH  = 8;
    localparam int AFULL  = 6;
    localparam int AEMPTY = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          write_en = 1'b0;
    logic [DW-1:0] write_data = '0;
    logic          read_en = 1'b0;
    logic          err_clr = 1'b0;

    logic [DW-1:0] s_rd, f_rd;
    logic          s_empty, s_full, s_afull, s_aempty, s_ovf, s_udf;
    logic          f_empty, f_full, f_afull, f_aempty, f_ovf, f_udf;
    logic [AW:0]   s_count, f_count;

    int checks = 0;
    int failures = 0;

    // Reference state
    logic [DW-1:0] q[$];
    logic          m_ovf = 1'b0;
    logic          m_udf = 1'b0;
    logic [DW-1:0] m_std_rd = '0;

    always #5 clk = ~clk;

    sync_fifo_flags #(
        .data_size(DW), .addr_size(AW), .afull_level(AFULL),
        .aempty_level(AEMPTY), .fwft(0)
    ) u_std (
        .clk(clk), .rst_n(rst_n), .write_en(write_en), .write_data(write_data),
        .read_en(read_en), .read_data(s_rd), .fifo_empty(s_empty),
        .fifo_full(s_full), .fifo_almost_full(s_afull),
        .fifo_almost_empty(s_aempty), .fifo_count(s_count),
        .overflow(s_ovf), .underflow(s_udf), .err_clr(err_clr)
    );

    sync_fifo_flags #(
        .data_size(DW), .addr_size(AW), .afull_level(AFULL),
        .aempty_level(AEMPTY), .fwft(1)
    ) u_fwft (
        .clk(clk), .rst_n(rst_n), .write_en(write_en), .write_data(write_data),
        .read_en(read_en), .read_data(f_rd), .fifo_empty(f_empty),
        .fifo_full(f_full), .fifo_almost_full(f_afull),
        .fifo_almost_empty(f_aempty), .fifo_count(f_count),
        .overflow(f_ovf), .underflow(f_udf), .err_clr(err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ph);
        int n;
        n = q.size();
        chk({ph, " std_count"},  32'(s_count),  32'(n));
        chk({ph, " fwft_count"}, 32'(f_count),  32'(n));
        chk({ph, " std_empty"},  32'(s_empty),  32'(n == 0));
        chk({ph, " fwft_empty"}, 32'(f_empty),  32'(n == 0));
        chk({ph, " std_full"},   32'(s_full),   32'(n == DEPTH));
        chk({ph, " fwft_full"},  32'(f_full),   32'(n == DEPTH));
        chk({ph, " std_afull"},  32'(s_afull),  32'(n >= AFULL));
        chk({ph, " fwft_afull"}, 32'(f_afull),  32'(n >= AFULL));
        chk({ph, " std_aempty"}, 32'(s_aempty), 32'(n <= AEMPTY));
        chk({ph, " fwft_aempty"},32'(f_aempty), 32'(n <= AEMPTY));
        chk({ph, " std_ovf"},    32'(s_ovf),    32'(m_ovf));
        chk({ph, " fwft_ovf"},   32'(f_ovf),    32'(m_ovf));
        chk({ph, " std_udf"},    32'(s_udf),    32'(m_udf));
        chk({ph, " fwft_udf"},   32'(f_udf),    32'(m_udf));
        chk({ph, " std_rdata"},  32'(s_rd),     32'(m_std_rd));
        if (n > 0) begin
            chk({ph, " fwft_rdata"}, 32'(f_rd), 32'(q[0]));
        end
    endtask

    // One clock cycle of stimulus, then update the reference and compare
    task automatic step(input logic we, input logic [DW-1:0] wd,
                        input logic re, input logic clr, input string ph);
        bit was_full, was_empty;
        write_en   = we;
        write_data = wd;
        read_en    = re;
        err_clr    = clr;
        was_full   = (q.size() == DEPTH);
        was_empty  = (q.size() == 0);
        @(posedge clk);
        if (re && !was_empty) m_std_rd = q.pop_front();
        if (we && !was_full)  q.push_back(wd);
        m_ovf = (we && was_full)  || (m_ovf && !clr);
        m_udf = (re && was_empty) || (m_udf && !clr);
        #1;
        check_all(ph);
    endtask

    // Assert reset between clock edges and check before any edge arrives
    task automatic reset_mid(input string ph);
        write_en = 1'b0;
        read_en  = 1'b0;
        err_clr  = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        m_ovf    = 1'b0;
        m_udf    = 1'b0;
        m_std_rd = '0;
        check_all(ph);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] d;
        int wr_pct;
        int rd_pct;

        // Asynchronous reset from power-up
        #12;
        reset_mid("reset");

        // Fill to full, then one write too many
        for (int i = 0; i < DEPTH; i++) begin
            d = 8'((i + 1) * 17);
            step(1'b1, d, 1'b0, 1'b0, "fill");
        end
        step(1'b1, 8'h99, 1'b0, 1'b0, "overflow");

        // Drain in order, then one read too many
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, "drain");
        end
        step(1'b0, 8'h00, 1'b1, 1'b0, "underflow");

        // Preload four, then stream read+write across pointer wraps
        d = 8'h20;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, d, 1'b0, 1'b0, "preload");
            d = d + 8'h01;
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b1, d, 1'b1, 1'b0, "stream");
            d = d + 8'h01;
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, "empty_out");
        end

        // Fall-through presentation of a single word
        step(1'b1, 8'hA5, 1'b0, 1'b0, "fwft_wr");
        step(1'b0, 8'h00, 1'b0, 1'b0, "fwft_hold");
        step(1'b0, 8'h00, 1'b1, 1'b0, "fwft_pop");

        // Error clear races, then reset with data in flight
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, "refill");
        end
        step(1'b1, 8'hEE, 1'b0, 1'b1, "clr_vs_set");
        step(1'b0, 8'h00, 1'b0, 1'b1, "clr_only");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, "to_five");
        end
        reset_mid("reset_mid");

        // Randomised traffic: write-heavy, read-heavy, then balanced
        for (int i = 0; i < 600; i++) begin
            if (i < 200)      begin wr_pct = 70; rd_pct = 30; end
            else if (i < 400) begin wr_pct = 30; rd_pct = 70; end
            else              begin wr_pct = 50; rd_pct = 50; end
            step(($urandom_range(0, 99) < wr_pct) ? 1'b1 : 1'b0,
                 8'($urandom),
                 ($urandom_range(0, 99) < rd_pct) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0,
                 "random");
        end

        reset_mid("reset_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
